// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB master command port between two clients
// Ports: pclk/presetn clock and async active-low reset; cN_req/we/addr/wdata client command in,
// cN_done/err/rdata completion out; m_wr_* / m_rd_* master handshake; busy/owner arbiter status.
module apb_req_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_done,
  output logic              c0_err,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_done,
  output logic              c1_err,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              m_wr_en,
  output logic [ADDR_W-1:0] m_wr_addr,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic              m_wr_done,
  output logic              m_rd_en,
  output logic [ADDR_W-1:0] m_rd_addr,
  input  logic [DATA_W-1:0] m_rd_data,
  input  logic              m_rd_valid,
  output logic              m_rd_done,
  output logic              busy,
  output logic              owner
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, owner_q, owner_d, we_q, we_d, busy_q, busy_d;
  logic wr_en_q, wr_en_d, rd_en_q, rd_en_d, rd_done_q, rd_done_d, gnt, hit;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] done_q, done_d, err_q, err_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_done_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      rd_done_q <= rd_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    rd_done_d = 1'b0;
    done_d    = '0;
    err_d     = '0;
    rdata_d   = rdata_q;
    // on a tie the client that was not served last wins
    gnt       = (c0_req && c1_req) ? ~ptr_q : c1_req;
    // only the response matching the issued command type counts
    hit       = we_q ? m_wr_done : m_rd_valid;
    case (state_q)
      IDLE: if (c0_req || c1_req) begin
        owner_d = gnt;
        ptr_d   = gnt;
        we_d    = gnt ? c1_we : c0_we;
        addr_d  = gnt ? c1_addr : c0_addr;
        wdata_d = gnt ? c1_wdata : c0_wdata;
        wr_en_d = we_d;
        rd_en_d = ~we_d;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (hit || cnt_d == TO) begin
          wr_en_d          = 1'b0;
          rd_en_d          = 1'b0;
          done_d[owner_q]  = 1'b1;
          err_d[owner_q]   = ~hit;
          rd_done_d        = hit && !we_q;
          if (!we_q) rdata_d[owner_q] = hit ? m_rd_data : '0;
          state_d          = RELEASE;
        end
      end
      RELEASE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  assign c0_done   = done_q[0];
  assign c1_done   = done_q[1];
  assign c0_err    = err_q[0];
  assign c1_err    = err_q[1];
  assign c0_rdata  = rdata_q[0];
  assign c1_rdata  = rdata_q[1];
  assign m_wr_en   = wr_en_q;
  assign m_rd_en   = rd_en_q;
  assign m_wr_addr = addr_q;
  assign m_rd_addr = addr_q;
  assign m_wr_data = wdata_q;
  assign m_rd_done = rd_done_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed stimulus with a transaction-level model checked every cycle
module tb_apb_req_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int TO = 255;
  logic pclk, presetn;
  logic c0_req, c0_we, c1_req, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic c0_done, c0_err, c1_done, c1_err;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic m_wr_en, m_wr_done, m_rd_en, m_rd_valid, m_rd_done, busy, owner;
  logic [AW-1:0] m_wr_addr, m_rd_addr;
  logic [DW-1:0] m_wr_data, m_rd_data;
  int checks = 0;
  int errors = 0;
  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_done(c0_done), .c0_err(c0_err), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_done(c1_done), .c1_err(c1_err), .c1_rdata(c1_rdata),
    .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_done(m_wr_done),
    .m_rd_en(m_rd_en), .m_rd_addr(m_rd_addr), .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid),
    .m_rd_done(m_rd_done), .busy(busy), .owner(owner)
  );
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask
  // model: one command in flight, aged per cycle; one idle cycle after each completion
  logic m_active, m_cool, m_last, m_owner, m_we, m_hit;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int m_age;
  logic e_wr_en, e_rd_en, e_busy, e_rd_done;
  logic [1:0] e_done, e_err;
  logic [DW-1:0] e_rdata [2];
  initial forever begin
    @(posedge pclk or negedge presetn);
    if (!presetn) begin
      m_active = 0; m_cool = 0; m_last = 1; m_owner = 0; m_we = 0; m_age = 0;
      m_addr = '0; m_wdata = '0; e_done = '0; e_err = '0; e_rd_done = 0;
      e_rdata[0] = '0; e_rdata[1] = '0;
    end else begin
      e_done = '0; e_err = '0; e_rd_done = 0;
      if (m_active) begin
        m_age++;
        m_hit = m_we ? m_wr_done : m_rd_valid;
        if (m_hit || m_age >= TO) begin
          e_done[m_owner] = 1'b1;
          e_err[m_owner] = !m_hit;
          if (!m_we) e_rdata[m_owner] = m_hit ? m_rd_data : '0;
          e_rd_done = m_hit && !m_we;
          m_active = 0;
          m_cool = 1;
        end
      end else if (m_cool) m_cool = 0;
      else if (c0_req || c1_req) begin
        m_owner = (c0_req && c1_req) ? !m_last : c1_req;
        m_last = m_owner;
        m_we = m_owner ? c1_we : c0_we;
        m_addr = m_owner ? c1_addr : c0_addr;
        m_wdata = m_owner ? c1_wdata : c0_wdata;
        m_active = 1;
        m_age = 0;
      end
    end
    e_wr_en = m_active && m_we;
    e_rd_en = m_active && !m_we;
    e_busy = m_active || m_cool;
  end
  initial forever begin
    @(posedge pclk);
    #1;
    if (presetn) begin
      chk("m_wr_en", 32'(m_wr_en), 32'(e_wr_en));
      chk("m_rd_en", 32'(m_rd_en), 32'(e_rd_en));
      chk("m_rd_done", 32'(m_rd_done), 32'(e_rd_done));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("c0_done", 32'(c0_done), 32'(e_done[0]));
      chk("c1_done", 32'(c1_done), 32'(e_done[1]));
      chk("c0_err", 32'(c0_err), 32'(e_err[0]));
      chk("c1_err", 32'(c1_err), 32'(e_err[1]));
      chk("c0_rdata", 32'(c0_rdata), 32'(e_rdata[0]));
      chk("c1_rdata", 32'(c1_rdata), 32'(e_rdata[1]));
      if (e_busy) chk("owner", 32'(owner), 32'(m_owner));
      if (e_wr_en) begin
        chk("m_wr_addr", 32'(m_wr_addr), 32'(m_addr));
        chk("m_wr_data", 32'(m_wr_data), 32'(m_wdata));
      end
      if (e_rd_en) chk("m_rd_addr", 32'(m_rd_addr), 32'(m_addr));
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int gap, n;
    bit seen;
    presetn = 0; c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
    m_wr_done = 0; m_rd_valid = 0; m_rd_data = '0;
    cyc(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_en", 32'(m_wr_en), 0);
    chk("rst_rd_en", 32'(m_rd_en), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_c0_rdata", 32'(c0_rdata), 0);
    chk("rst_c1_done", 32'(c1_done), 0);
    presetn = 1;
    cyc(1);
    // client 0 write, master done three cycles after enable
    c0_req = 1; c0_we = 1; c0_addr = 9'h049; c0_wdata = 16'hA4B8;
    cyc(1);
    chk("w_en", 32'(m_wr_en), 1);
    chk("w_addr", 32'(m_wr_addr), 32'h049);
    chk("w_data", 32'(m_wr_data), 32'hA4B8);
    cyc(2);
    chk("w_en_hold", 32'(m_wr_en), 1);
    chk("w_done_early", 32'(c0_done), 0);
    m_wr_done = 1;
    cyc(1);
    chk("w_en_drop", 32'(m_wr_en), 0);
    chk("w_done", 32'(c0_done), 1);
    chk("w_err", 32'(c0_err), 0);
    chk("w_c1_done", 32'(c1_done), 0);
    chk("w_busy_rel", 32'(busy), 1);
    m_wr_done = 0; c0_req = 0;
    cyc(1);
    chk("w_done_pulse", 32'(c0_done), 0);
    chk("w_busy_idle", 32'(busy), 0);
    // client 1 read
    c1_req = 1; c1_we = 0; c1_addr = 9'h100;
    cyc(1);
    chk("r_en", 32'(m_rd_en), 1);
    chk("r_addr", 32'(m_rd_addr), 32'h100);
    chk("r_owner", 32'(owner), 1);
    m_rd_valid = 1; m_rd_data = 16'h5A5A;
    cyc(1);
    chk("r_done", 32'(c1_done), 1);
    chk("r_mdone", 32'(m_rd_done), 1);
    chk("r_data", 32'(c1_rdata), 32'h5A5A);
    chk("r_en_drop", 32'(m_rd_en), 0);
    chk("r_c0_done", 32'(c0_done), 0);
    m_rd_valid = 0; c1_req = 0;
    cyc(1);
    chk("r_mdone_pulse", 32'(m_rd_done), 0);
    chk("r_data_hold", 32'(c1_rdata), 32'h5A5A);
    cyc(1);
    // both request from reset, both keep requesting
    presetn = 0;
    cyc(1);
    presetn = 1;
    c0_req = 1; c0_we = 1; c0_addr = 9'h001; c0_wdata = 16'h1357;
    c1_req = 1; c1_we = 0; c1_addr = 9'h101;
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      while (!(m_wr_en || m_rd_en) && gap < 20) begin
        gap++;
        cyc(1);
      end
      if (k > 0) chk("rr_gap", gap, 2);
      chk("rr_owner", 32'(owner), k % 2);
      chk("rr_wr_en", 32'(m_wr_en), 1 - k % 2);
      if (m_wr_en) m_wr_done = 1;
      else begin
        m_rd_valid = 1;
        m_rd_data = 16'hC000 + 16'(k);
      end
      cyc(1);
      chk("rr_done", 32'((k % 2) ? c1_done : c0_done), 1);
      if (k % 2 == 1) chk("rr_rdata", 32'(c1_rdata), 32'hC000 + k);
      m_wr_done = 0; m_rd_valid = 0;
    end
    c0_req = 0; c1_req = 0;
    cyc(2);
    // wrong-type response ignored during a read
    c0_req = 1; c0_we = 0; c0_addr = 9'h0F0;
    cyc(1);
    chk("x_rd_en", 32'(m_rd_en), 1);
    m_wr_done = 1;
    cyc(1);
    chk("x_rd_en_hold", 32'(m_rd_en), 1);
    chk("x_no_done", 32'(c0_done), 0);
    cyc(1);
    chk("x_rd_en_hold2", 32'(m_rd_en), 1);
    m_wr_done = 0; m_rd_valid = 1; m_rd_data = 16'hBEEF;
    cyc(1);
    chk("x_done", 32'(c0_done), 1);
    chk("x_rdata", 32'(c0_rdata), 32'hBEEF);
    chk("x_mdone", 32'(m_rd_done), 1);
    m_rd_valid = 0; c0_req = 0;
    cyc(2);
    // read with no master response times out
    c0_req = 1; c0_we = 0; c0_addr = 9'h0AA;
    cyc(1);
    n = 0; seen = 0;
    while (m_rd_en && n < 400) begin
      if (m_rd_done) seen = 1;
      n++;
      cyc(1);
    end
    chk("to_cycles", n, 255);
    chk("to_done", 32'(c0_done), 1);
    chk("to_err", 32'(c0_err), 1);
    chk("to_rdata", 32'(c0_rdata), 0);
    chk("to_mdone", 32'(m_rd_done), 0);
    chk("to_mdone_seen", 32'(seen), 0);
    c0_req = 0;
    cyc(2);
    c0_req = 1; c0_we = 1; c0_addr = 9'h1F0; c0_wdata = 16'h0F0F;
    cyc(1);
    chk("to_next_en", 32'(m_wr_en), 1);
    m_wr_done = 1;
    cyc(1);
    chk("to_next_done", 32'(c0_done), 1);
    chk("to_next_err", 32'(c0_err), 0);
    m_wr_done = 0; c0_req = 0;
    cyc(2);
    // asynchronous reset mid-write, then pointer back to client 0 first
    c0_req = 1; c0_we = 1; c0_addr = 9'h055; c0_wdata = 16'hAAAA;
    cyc(1);
    chk("ar_en", 32'(m_wr_en), 1);
    cyc(1);
    presetn = 0;
    #1;
    chk("ar_wr_en", 32'(m_wr_en), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_done", 32'(c0_done), 0);
    cyc(1);
    presetn = 1;
    c1_req = 1; c1_we = 0; c1_addr = 9'h1AA;
    cyc(1);
    chk("ar_owner0", 32'(owner), 0);
    chk("ar_wr_en2", 32'(m_wr_en), 1);
    m_wr_done = 1;
    cyc(1);
    chk("ar_c0_done", 32'(c0_done), 1);
    m_wr_done = 0; c0_req = 0;
    cyc(2);
    chk("ar_owner1", 32'(owner), 1);
    chk("ar_rd_en", 32'(m_rd_en), 1);
    m_rd_valid = 1; m_rd_data = 16'h1234;
    cyc(1);
    chk("ar_c1_done", 32'(c1_done), 1);
    chk("ar_c1_rdata", 32'(c1_rdata), 32'h1234);
    m_rd_valid = 0; c1_req = 0;
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single APB master's processor-side command interface between two requesting clients (client 0, client 1).
- Accepts one read or write command per client, arbitrates round-robin and drives the master's wr_en/rd_en handshake. Returns completion, read data and a timeout error to the owning client.
- Sits between the processor-side clients and the APB master. One command is outstanding at the master at a time.

Parameters:
ADDR_W, 9, command address width; MSB selects peripheral (1 = psel2, 0 = psel1), passed through unmodified
DATA_W, 16, read/write data width
TIMEOUT, 255, max cycles in ISSUE before abort; counter width clog2(TIMEOUT+1)

Ports:
pclk  in  1  clock, rising edge
presetn  in  1  asynchronous active-low reset
c0_req  in  1  client 0 command request; held with command fields stable until c0_done
c0_we  in  1  client 0: 1 = write, 0 = read
c0_addr  in  ADDR_W  client 0 address
c0_wdata  in  DATA_W  client 0 write data
c0_done  out  1  one-cycle completion pulse to client 0
c0_err  out  1  valid with c0_done; 1 = timed out
c0_rdata  out  DATA_W  client 0 read data; valid with c0_done, held until next client 0 read
c1_req, c1_we, c1_addr, c1_wdata, c1_done, c1_err, c1_rdata  same as client 0, for client 1
m_wr_en  out  1  to master wr_en
m_wr_addr  out  ADDR_W  to master wr_addr
m_wr_data  out  DATA_W  to master wr_data
m_wr_done  in  1  from master: write complete
m_rd_en  out  1  to master rd_en
m_rd_addr  out  ADDR_W  to master rd_addr
m_rd_data  in  DATA_W  from master rd_data
m_rd_valid  in  1  from master: m_rd_data valid
m_rd_done  out  1  to master rd_done; one-cycle pulse, data consumed
busy  out  1  high in any state other than IDLE
owner  out  1  client currently granted; meaningful only while busy

Behaviour:
- All outputs registered.
- Reset (presetn low, asynchronous, any state including mid-transfer):
  - state = IDLE; all outputs 0; cN_rdata = 0.
  - last-served pointer = 1, so client 0 wins the first tie; timeout counter = 0.
- FSM states: IDLE, ISSUE, RELEASE.
- IDLE:
  - No request: stay.
  - Exactly one cN_req: grant client N.
  - Both requesting: grant the client not equal to the last-served pointer.
  - On grant: latch we/addr/wdata into command registers; set owner; update pointer to N; go to ISSUE.
  - In the same edge, assert m_wr_en (we=1) or m_rd_en (we=0) with the latched address/data. Command visible at the master 1 cycle after cN_req is sampled.
- ISSUE:
  - m_*_addr and m_wr_data held constant; timeout counter increments every cycle.
  - Write: m_wr_done sampled high -> drop m_wr_en; pulse cN_done=1, cN_err=0; go to RELEASE.
  - Read: m_rd_valid sampled high -> capture m_rd_data into cN_rdata; drop m_rd_en; pulse m_rd_done and cN_done=1, cN_err=0; go to RELEASE.
  - Counter reaches TIMEOUT with no done/valid -> drop enable; pulse cN_done=1, cN_err=1; cN_rdata=0 for reads; m_rd_done not pulsed; go to RELEASE.
  - m_wr_done/m_rd_valid that does not match the issued command type is ignored.
  - Done/valid and timeout in the same cycle: completion wins, err=0.
- RELEASE:
  - One cycle with both enables low; clear counter; go to IDLE. Guarantees the master sees enable low for at least 2 cycles between commands.
- Requester rule:
  - Client deasserts req on the cycle after its cN_done. A req still high in IDLE is a new command.
  - Back-to-back: the other client wins if requesting.
- Non-owner isolation: the non-owning client's done/err/rdata are unaffected. Its req may change freely while not owner.
- Throughput: minimum 3 cycles per command (grant/issue, done, release) plus master latency.

Test Plan:
- Client 0 write, addr 9'h049, data 16'hA4B8; m_wr_done high 3 cycles after m_wr_en -> m_wr_en=1, m_wr_addr=9'h049, m_wr_data=16'hA4B8 for exactly those cycles; c0_done one pulse, c0_err=0; c1_done stays 0.
- Client 1 read, addr 9'h100; master returns m_rd_valid with m_rd_data=16'h5A5A -> m_rd_en=1, m_rd_addr=9'h100; c1_rdata=16'h5A5A; c1_done and m_rd_done single pulses in the same cycle.
- Both clients request from reset in the same cycle (c0 write 9'h001, c1 read 9'h101), both hold req after done -> order c0, c1, c0, c1; owner alternates; at least one enable-low cycle between commands.
- Client 0 read, master never responds -> after TIMEOUT=255 cycles in ISSUE, m_rd_en falls; c0_done=1, c0_err=1, c0_rdata=16'h0000; m_rd_done never pulses; next request accepted normally.
- presetn pulsed low while m_wr_en=1 mid-write -> m_wr_en, busy, c0_done drop immediately (asynchronously); after release, both clients requesting -> client 0 granted first.
- m_wr_done asserted during a read command -> ignored, m_rd_en stays high until m_rd_valid.
